// File: rtl/commit_queue.sv
// Retirement commit queue: up to two commits plus one trap per cycle are
// enqueued in order and drained one per cycle toward the co-simulation checker.
module commit_queue #(
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     c0_valid,
  input  logic [63:0]              c0_pc,
  input  logic [31:0]              c0_insn,
  input  logic                     c0_wen,
  input  logic [4:0]               c0_waddr,
  input  logic [63:0]              c0_wdata,
  input  logic                     c1_valid,
  input  logic [63:0]              c1_pc,
  input  logic [31:0]              c1_insn,
  input  logic                     c1_wen,
  input  logic [4:0]               c1_waddr,
  input  logic [63:0]              c1_wdata,
  input  logic                     trap_valid,
  input  logic [63:0]              trap_cause,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_insn,
  output logic                     out_wen,
  output logic [4:0]               out_waddr,
  output logic [63:0]              out_data,
  output logic [SEQW-1:0]          out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            kind;
    logic [63:0]     pc;
    logic [31:0]     insn;
    logic            wen;
    logic [4:0]      waddr;
    logic [63:0]     data;
    logic [SEQW-1:0] seq;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d;
  entry_t          cand   [3];
  entry_t          wentry [3];
  logic [2:0]      cvld;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, off;
  logic [CW-1:0]   count_q, count_d, free, nacc, ndrop;
  logic [SEQW-1:0] seq_q, seq_d;
  logic            ovf_q, ovf_d, deq;
  logic [15:0]     drop_q, drop_d;
  logic [16:0]     drop_sum;

  always_comb begin
    cand[0] = '{kind: 1'b0, pc: c0_pc, insn: c0_insn, wen: c0_wen,
                waddr: c0_waddr, data: c0_wdata, seq: '0};
    cand[1] = '{kind: 1'b0, pc: c1_pc, insn: c1_insn, wen: c1_wen,
                waddr: c1_waddr, data: c1_wdata, seq: '0};
    cand[2] = '{kind: 1'b1, pc: '0, insn: '0, wen: 1'b0,
                waddr: '0, data: trap_cause, seq: '0};
    cvld    = reset ? 3'b000 : {trap_valid, c1_valid, c0_valid};
  end

  // Free space is taken at cycle start so a same-cycle dequeue never makes room.
  always_comb begin
    free  = CW'(DEPTH) - count_q;
    nacc  = '0;
    ndrop = '0;
    for (int i = 0; i < 3; i++) wentry[i] = '0;
    for (int i = 0; i < 3; i++) begin
      if (cvld[i]) begin
        if (nacc < free) begin
          wentry[nacc[1:0]]     = cand[i];
          wentry[nacc[1:0]].seq = seq_q + SEQW'(nacc);
          nacc = nacc + CW'(1);
        end else begin
          ndrop = ndrop + CW'(1);
        end
      end
    end
  end

  always_comb begin
    deq      = (count_q != '0) & out_ready & ~reset;
    count_d  = count_q + nacc - CW'(deq);
    wptr_d   = wptr_q + nacc[AW-1:0];
    rptr_d   = rptr_q + AW'(deq);
    seq_d    = seq_q + SEQW'(nacc);
    drop_sum = {1'b0, drop_q} + 17'(ndrop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d    = ovf_q | (ndrop != '0);
    // Next head may be an entry being written this very edge (queue was empty).
    off      = rptr_d - wptr_q;
    head_d   = head_q;
    if (count_d != '0) begin
      if (CW'(off) < nacc) head_d = wentry[off[1:0]];
      else                 head_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++)
      if (CW'(k) < nacc) mem_q[wptr_q + AW'(k)] <= wentry[k];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      head_q  <= head_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_kind  = head_q.kind;
  assign out_pc    = head_q.pc;
  assign out_insn  = head_q.insn;
  assign out_wen   = head_q.wen;
  assign out_waddr = head_q.waddr;
  assign out_data  = head_q.data;
  assign out_seq   = head_q.seq;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_commit_queue.sv
// Bench for commit_queue: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_commit_queue;
  localparam int DEPTH = 8;
  localparam int SEQW  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        c0_valid, c1_valid, trap_valid, out_ready;
  logic [63:0] c0_pc, c1_pc, c0_wdata, c1_wdata, trap_cause;
  logic [31:0] c0_insn, c1_insn;
  logic        c0_wen, c1_wen;
  logic [4:0]  c0_waddr, c1_waddr;
  logic        out_valid, out_kind, out_wen, overflow;
  logic [63:0] out_pc, out_data;
  logic [31:0] out_insn;
  logic [4:0]  out_waddr;
  logic [SEQW-1:0] out_seq;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  always #5 clock = ~clock;

  commit_queue #(.DEPTH(DEPTH), .SEQW(SEQW)) dut (
    .clock(clock), .reset(reset),
    .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_insn(c0_insn), .c0_wen(c0_wen),
    .c0_waddr(c0_waddr), .c0_wdata(c0_wdata),
    .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_insn(c1_insn), .c1_wen(c1_wen),
    .c1_waddr(c1_waddr), .c1_wdata(c1_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen),
    .out_waddr(out_waddr), .out_data(out_data), .out_seq(out_seq),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    bit        kind;
    bit [63:0] pc;
    bit [31:0] insn;
    bit        wen;
    bit [4:0]  waddr;
    bit [63:0] data;
    bit [15:0] seq;
  } ent_t;

  ent_t      mq[$];
  ent_t      last;
  bit [15:0] mseq;
  int        mdrop;
  bit        movf;
  int        n_cmp = 0;
  int        n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input ent_t e, inout int acc, inout int free, inout int nd);
    if (acc < free) begin
      e.seq = mseq;
      mseq  = mseq + 16'd1;
      mq.push_back(e);
      acc++;
    end else nd++;
  endtask

  // Reference: space is judged before the dequeue, candidates taken c0, c1, trap.
  task automatic model_edge();
    ent_t e;
    int free, acc, nd;
    if (reset) begin
      mq.delete(); mseq = 0; mdrop = 0; movf = 0; last = '{default: 0};
      return;
    end
    free = DEPTH - mq.size(); acc = 0; nd = 0;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (c0_valid) begin
      e = '{0, c0_pc, c0_insn, c0_wen, c0_waddr, c0_wdata, 0};
      offer(e, acc, free, nd);
    end
    if (c1_valid) begin
      e = '{0, c1_pc, c1_insn, c1_wen, c1_waddr, c1_wdata, 0};
      offer(e, acc, free, nd);
    end
    if (trap_valid) begin
      e = '{1, 0, 0, 0, 0, trap_cause, 0};
      offer(e, acc, free, nd);
    end
    mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
    if (nd > 0) movf = 1;
    if (mq.size() > 0) last = mq[0];
  endtask

  task automatic check_all();
    chk("count", count, mq.size());
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_kind", out_kind, last.kind);
    chk("out_pc", out_pc, last.pc);
    chk("out_insn", out_insn, last.insn);
    chk("out_wen", out_wen, last.wen);
    chk("out_waddr", out_waddr, last.waddr);
    chk("out_data", out_data, last.data);
    chk("out_seq", out_seq, last.seq);
    chk("overflow", overflow, movf);
    chk("drop_cnt", drop_cnt, mdrop);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();
    c0_valid = 0; c1_valid = 0; trap_valid = 0;
  endtask

  task automatic rnd_data();
    c0_pc = {$urandom, $urandom}; c0_insn = $urandom; c0_wen = 1'($urandom);
    c0_waddr = 5'($urandom); c0_wdata = {$urandom, $urandom};
    c1_pc = {$urandom, $urandom}; c1_insn = $urandom; c1_wen = 1'($urandom);
    c1_waddr = 5'($urandom); c1_wdata = {$urandom, $urandom};
    trap_cause = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  initial begin
    logic [63:0] saved_pc;
    int sent;
    reset = 1; out_ready = 0; idle(); rnd_data();
    cycle(); cycle();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 0;

    // single commit
    rnd_data(); c0_valid = 1; c0_pc = 64'h8000_0000; c0_insn = 32'h13; out_ready = 1;
    cycle();
    chk("single_valid", out_valid, 1);
    chk("single_kind", out_kind, 0);
    chk("single_seq", out_seq, 0);
    chk("single_pc", out_pc, 64'h8000_0000);
    idle(); cycle();
    chk("single_drain", count, 0);

    // dual commit plus trap
    do_reset();
    rnd_data(); out_ready = 0;
    c0_valid = 1; c0_pc = 64'h100; c1_valid = 1; c1_pc = 64'h104;
    trap_valid = 1; trap_cause = 64'h8;
    cycle();
    chk("dual_count", count, 3);
    idle(); out_ready = 1;
    chk("dual_h0_pc", out_pc, 64'h100); chk("dual_h0_seq", out_seq, 0);
    cycle();
    chk("dual_h1_pc", out_pc, 64'h104); chk("dual_h1_seq", out_seq, 1);
    cycle();
    chk("dual_h2_kind", out_kind, 1); chk("dual_h2_data", out_data, 64'h8);
    chk("dual_h2_seq", out_seq, 2);
    cycle();
    chk("dual_empty", count, 0);

    // overflow, then full with concurrent dequeue
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 7; i++) begin rnd_data(); idle(); c0_valid = 1; cycle(); end
    rnd_data(); saved_pc = c0_pc; c0_valid = 1; c1_valid = 1; trap_valid = 1;
    cycle();
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_cnt, 2);
    rnd_data(); idle(); c0_valid = 1; out_ready = 1;
    cycle();
    chk("fulldeq_count", count, 7);
    chk("fulldeq_drops", drop_cnt, 3);
    idle();
    for (int i = 0; i < 6; i++) cycle();
    chk("ovf_acc_pc", out_pc, saved_pc);
    chk("ovf_acc_seq", out_seq, 7);
    chk("ovf_acc_kind", out_kind, 0);

    // pointer wrap: 20 commits, ready toggling
    do_reset();
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      rnd_data(); idle();
      c0_valid = (i % 2 == 0) && (sent < 20);
      if (c0_valid) sent++;
      out_ready = (i % 2 == 0);
      cycle();
    end
    idle(); out_ready = 1;
    for (int i = 0; i < 30 && count != 0; i++) cycle();
    chk("wrap_empty", count, 0);
    chk("wrap_drops", drop_cnt, 0);
    chk("wrap_ovf", overflow, 0);
    chk("wrap_last_seq", out_seq, 19);

    // reset mid-run with inputs active during reset
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin rnd_data(); idle(); c0_valid = 1; cycle(); end
    rnd_data(); c0_valid = 1; c1_valid = 1; trap_valid = 1; reset = 1;
    cycle();
    reset = 0; idle();
    chk("midrst_count", count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", overflow, 0);
    cycle();
    chk("midrst_first_valid", out_valid, 0);
    rnd_data(); c0_valid = 1;
    cycle();
    chk("midrst_seq", out_seq, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rnd_data();
      c0_valid = ($urandom_range(0, 99) < 50);
      c1_valid = ($urandom_range(0, 99) < 35);
      trap_valid = ($urandom_range(0, 99) < 15);
      out_ready = ($urandom_range(0, 99) < 55);
      reset = ($urandom_range(0, 99) < 2);
      cycle();
    end
    reset = 0;

    // drop counter saturation
    out_ready = 0; c0_valid = 1; c1_valid = 1; trap_valid = 1;
    for (int i = 0; i < 30000 && mdrop < 65535; i++) cycle();
    for (int i = 0; i < 3; i++) cycle();
    chk("drop_sat", drop_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
